// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner and the seven-segment display
// decoder: scan FSM state encoding, column-drive reset value and the
// (column, row) -> hex key-code map.
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_t;

    localparam logic [3:0] COL_RESET = 4'b0001;

    // Physical keypad legend, column-major: column c, row r -> hex code.
    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        code = 4'h0;
        case ({c, r})
            4'b00_00: code = 4'hA;
            4'b00_01: code = 4'h7;
            4'b00_10: code = 4'h4;
            4'b00_11: code = 4'h1;
            4'b01_00: code = 4'h0;
            4'b01_01: code = 4'h8;
            4'b01_10: code = 4'h5;
            4'b01_11: code = 4'h2;
            4'b10_00: code = 4'hB;
            4'b10_01: code = 4'h9;
            4'b10_10: code = 4'h6;
            4'b10_11: code = 4'h3;
            4'b11_00: code = 4'hF;
            4'b11_01: code = 4'hE;
            4'b11_10: code = 4'hD;
            4'b11_11: code = 4'hC;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Free-running divider producing a one-cycle scan tick every TICK_DIV clocks.
// The counter runs 0..TICK_DIV-1; tick is high while it sits at TICK_DIV-1.
//
// Parameters: TICK_DIV  clk cycles per tick (>= 2)
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (counter -> 0)
//   tick  out  one-cycle scan tick
// -----------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int TICK_DIV = 4800
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
// 4x4 keypad scanner: rotates a one-hot column strobe at the scan-tick rate,
// samples the rows once per tick, debounces press and release over DEBOUNCE_N
// ticks, emits one key_valid pulse per physical press and keeps a two-digit
// history for the display multiplexer.
//
// Parameters: TICK_DIV   clk cycles per scan tick (>= 2)
//             DEBOUNCE_N matching ticks needed to accept press / release (1..255)
// Build option: KEYPAD_GHOST_REJECT_EN -- when defined, a row sample is valid
//   only with exactly one row high; otherwise any non-zero sample is valid and
//   the lowest set row is taken.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   row_d[3:0] in   synchronized row inputs, high = contact
//   col_q[3:0] out  one-hot column drive
//   key_code   out  code of last accepted key
//   key_valid  out  one-cycle pulse per accepted press
//   key_held   out  high while an accepted key is not yet released
//   digit_new  out  most recent accepted key
//   digit_old  out  key accepted before digit_new
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int TICK_DIV   = 4800,
    parameter int DEBOUNCE_N = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_d,
    output logic [3:0] col_q,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    import keypad_pkg::*;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_N);

    logic       w_tick;
    kp_state_t  r_state, w_state_nxt;
    logic [3:0] w_col_nxt;
    logic [1:0] r_row_idx, w_row_idx_nxt;
    logic [1:0] r_col_idx, w_col_idx_nxt;
    logic [7:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic       w_accept;
    logic [3:0] w_code;

    logic [1:0] w_low_row;
    logic [1:0] w_col_enc;
    logic [3:0] w_col_rot;
    logic       w_row_any;
    logic       w_row_one;
    logic       w_sample_ok;
    logic       w_press_match;
    logic       w_row_watched;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Row sample decode
    always_comb begin
        w_low_row = 2'd3;
        if (row_d[0])      w_low_row = 2'd0;
        else if (row_d[1]) w_low_row = 2'd1;
        else if (row_d[2]) w_low_row = 2'd2;

        w_col_enc = 2'd0;
        case (col_q)
            4'b0001: w_col_enc = 2'd0;
            4'b0010: w_col_enc = 2'd1;
            4'b0100: w_col_enc = 2'd2;
            4'b1000: w_col_enc = 2'd3;
            default: w_col_enc = 2'd0;
        endcase
    end

    assign w_col_rot     = {col_q[2:0], col_q[3]};
    assign w_row_any     = |row_d;
    assign w_row_one     = w_row_any && ((row_d & (row_d - 4'd1)) == 4'd0);
    assign w_row_watched = row_d[r_row_idx];
    // Counter never needs to exceed DEBOUNCE_N; hold it there if it gets there.
    assign w_cnt_inc     = (r_cnt >= DEB_LAST) ? DEB_LAST : r_cnt + 8'd1;

`ifdef KEYPAD_GHOST_REJECT_EN
    assign w_sample_ok   = w_row_one;
    assign w_press_match = (row_d == (4'b0001 << r_row_idx));
`else
    assign w_sample_ok   = w_row_any;
    assign w_press_match = w_row_watched;
`endif

    // Next-state / next-data logic; everything holds between ticks.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = col_q;
        w_row_idx_nxt = r_row_idx;
        w_col_idx_nxt = r_col_idx;
        w_cnt_nxt     = r_cnt;
        w_accept      = 1'b0;

        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_sample_ok) begin
                        w_row_idx_nxt = w_low_row;
                        w_col_idx_nxt = w_col_enc;
                        w_cnt_nxt     = 8'd1;
                        if (DEB_LAST == 8'd1) begin
                            w_state_nxt = HELD;
                            w_accept    = 1'b1;
                        end else begin
                            w_state_nxt = DEB_PRESS;
                        end
                    end else begin
                        w_col_nxt = w_col_rot;
                    end
                end
                DEB_PRESS: begin
                    if (w_press_match) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == DEB_LAST) begin
                            w_state_nxt = HELD;
                            w_accept    = 1'b1;
                        end
                    end else begin
                        w_state_nxt = SCAN;
                        w_col_nxt   = w_col_rot;
                        w_cnt_nxt   = 8'd0;
                    end
                end
                HELD: begin
                    // Only the accepted row is watched; other rows are ignored.
                    if (!w_row_watched) begin
                        if (DEB_LAST == 8'd1) begin
                            w_state_nxt = SCAN;
                            w_col_nxt   = w_col_rot;
                            w_cnt_nxt   = 8'd0;
                        end else begin
                            w_state_nxt = DEB_REL;
                            w_cnt_nxt   = 8'd1;
                        end
                    end
                end
                DEB_REL: begin
                    if (!w_row_watched) begin
                        if (w_cnt_inc == DEB_LAST) begin
                            w_state_nxt = SCAN;
                            w_col_nxt   = w_col_rot;
                            w_cnt_nxt   = 8'd0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        // Release bounce: back to held, no new key event.
                        w_state_nxt = HELD;
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    assign w_code = key_map(w_col_idx_nxt, w_row_idx_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= COL_RESET;
            r_row_idx <= 2'd0;
            r_col_idx <= 2'd0;
            r_cnt     <= 8'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            digit_new <= 4'd0;
            digit_old <= 4'd0;
        end else begin
            col_q     <= w_col_nxt;
            r_row_idx <= w_row_idx_nxt;
            r_col_idx <= w_col_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            key_valid <= w_accept;
            key_held  <= (w_state_nxt == HELD) || (w_state_nxt == DEB_REL);
            if (w_accept) begin
                key_code  <= w_code;
                digit_old <= digit_new;
                digit_new <= w_code;
            end
        end
    end

endmodule
